// File: rtl/mac_row_sequencer.sv
// Purpose: sequence A*b+C limb by limb through an external MAC, linking limbs via the MAC carry chain.
// Latency: result limb i appears MAC_LATENCY enabled cycles after operand limb i; carry limb follows the last.
// Backpressure: res_ready low on a valid result freezes the MAC (MulAccEn=0) and deasserts in_ready.
module mac_row_sequencer #(
  parameter int CP_D_WIDTH  = 72,
  parameter int MAC_LATENCY = 6,
  parameter int MAX_LIMBS   = 16,
  parameter int LCW         = 5
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  start,
  input  logic [CP_D_WIDTH-1:0] b_word,
  input  logic [LCW-1:0]        num_limbs,
  output logic                  busy,
  output logic                  done,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [CP_D_WIDTH-1:0] in_a,
  input  logic [CP_D_WIDTH-1:0] in_c,
  output logic                  res_valid,
  input  logic                  res_ready,
  output logic [CP_D_WIDTH-1:0] res_word,
  output logic [LCW-1:0]        res_index,
  output logic                  res_last,
  output logic                  MulAccEn,
  output logic                  ArithOp,
  output logic                  ArithRegOp,
  output logic [CP_D_WIDTH-1:0] IN_REG0,
  output logic [CP_D_WIDTH-1:0] IN_REG1,
  output logic [CP_D_WIDTH-1:0] IN_REG2,
  input  logic [CP_D_WIDTH-1:0] mac_out,
  input  logic [CP_D_WIDTH-1:0] mac_carry
);

  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, CARRY} state_t;

  state_t                  state;
  logic [CP_D_WIDTH-1:0]   b_reg;
  logic [LCW-1:0]          n_reg;
  logic [LCW-1:0]          in_cnt;
  logic [LCW-1:0]          out_cnt;
  // Token pipe mirrors the MAC pipeline; bit MAC_LATENCY-1 is the output slot.
  logic [MAC_LATENCY-1:0]  tok_vld;
  logic [MAC_LATENCY-1:0]  tok_first;
  logic [MAC_LATENCY-1:0]  tok_last;

  logic active;
  logic out_vld;
  logic out_fire;
  logic in_fire;
  logic start_ok;

  assign active   = (state == ISSUE) || (state == DRAIN);
  assign out_vld  = active && tok_vld[MAC_LATENCY-1];
  // A valid result that downstream refuses freezes the whole MAC pipe.
  assign MulAccEn = active && !(out_vld && !res_ready);
  assign in_ready = (state == ISSUE) && MulAccEn;
  assign in_fire  = in_ready && in_valid;
  assign out_fire = out_vld && MulAccEn;
  assign start_ok = start && (num_limbs != '0) && (num_limbs <= LCW'(MAX_LIMBS));

  assign busy       = (state != IDLE);
  assign done       = (state == CARRY) && res_ready;
  assign res_valid  = out_vld || (state == CARRY);
  assign res_last   = (state == CARRY);
  assign res_word   = (state == CARRY) ? mac_carry : (out_vld ? mac_out : '0);
  assign res_index  = (state == CARRY) ? n_reg : (out_vld ? out_cnt : '0);
  // Limb 0 must not pick up whatever carry the previous job left behind.
  assign ArithOp    = out_vld && !tok_first[MAC_LATENCY-1];
  // Carry advances only when a real limb leaves the MAC; bubbles and fill hold it.
  assign ArithRegOp = !out_vld;
  assign IN_REG0    = in_fire ? in_a : '0;
  assign IN_REG1    = b_reg;
  assign IN_REG2    = in_fire ? in_c : '0;

  // FSM, limb counters, latched multiplier and token pipe.
  always_ff @(posedge clock) begin
    if (reset) begin
      state     <= IDLE;
      b_reg     <= '0;
      n_reg     <= '0;
      in_cnt    <= '0;
      out_cnt   <= '0;
      tok_vld   <= '0;
      tok_first <= '0;
      tok_last  <= '0;
    end else begin
      if (MulAccEn) begin
        tok_vld   <= {tok_vld[MAC_LATENCY-2:0], in_fire};
        tok_first <= {tok_first[MAC_LATENCY-2:0], in_fire && (in_cnt == '0)};
        tok_last  <= {tok_last[MAC_LATENCY-2:0], in_fire && (in_cnt == n_reg - LCW'(1))};
      end
      if (in_fire) in_cnt <= in_cnt + LCW'(1);
      if (out_fire) out_cnt <= out_cnt + LCW'(1);
      case (state)
        IDLE: begin
          if (start_ok) begin
            b_reg     <= b_word;
            n_reg     <= num_limbs;
            in_cnt    <= '0;
            out_cnt   <= '0;
            tok_vld   <= '0;
            tok_first <= '0;
            tok_last  <= '0;
            state     <= ISSUE;
          end
        end
        ISSUE: if (in_fire && (in_cnt == n_reg - LCW'(1))) state <= DRAIN;
        DRAIN: if (out_fire && tok_last[MAC_LATENCY-1]) state <= CARRY;
        CARRY: if (res_ready) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mac_row_sequencer.sv
// Bench for mac_row_sequencer: behavioural MAC plus scoreboard of expected result limbs.
// Each scenario task drives a job and compares results as they are accepted.
// Results are sampled 1ns after the falling edge, inputs change on the falling edge.
module tb_mac_row_sequencer;
  localparam int W = 72;
  localparam int L = 6;

  logic          clock = 0;
  logic          reset;
  logic          start;
  logic [W-1:0]  b_word;
  logic [4:0]    num_limbs;
  logic          busy, done;
  logic          in_valid, in_ready;
  logic [W-1:0]  in_a, in_c;
  logic          res_valid, res_ready, res_last;
  logic [W-1:0]  res_word;
  logic [4:0]    res_index;
  logic          MulAccEn, ArithOp, ArithRegOp;
  logic [W-1:0]  IN_REG0, IN_REG1, IN_REG2;
  logic [W-1:0]  mac_out, mac_carry;

  mac_row_sequencer dut (
    .clock(clock), .reset(reset), .start(start), .b_word(b_word), .num_limbs(num_limbs),
    .busy(busy), .done(done), .in_valid(in_valid), .in_ready(in_ready), .in_a(in_a), .in_c(in_c),
    .res_valid(res_valid), .res_ready(res_ready), .res_word(res_word), .res_index(res_index),
    .res_last(res_last), .MulAccEn(MulAccEn), .ArithOp(ArithOp), .ArithRegOp(ArithRegOp),
    .IN_REG0(IN_REG0), .IN_REG1(IN_REG1), .IN_REG2(IN_REG2), .mac_out(mac_out), .mac_carry(mac_carry)
  );

  always #5 clock = ~clock;

  // Behavioural mul_acc: L-stage product pipe and a carry register, both frozen when disabled.
  logic [2*W-1:0] mpipe [L];
  logic [W-1:0]   mcarry;
  logic [2*W-1:0] msum;
  assign msum      = mpipe[L-1] + (ArithOp ? {{W{1'b0}}, mcarry} : '0);
  assign mac_out   = msum[W-1:0];
  assign mac_carry = mcarry;
  always @(posedge clock) begin
    if (reset) begin
      for (int s = 0; s < L; s++) mpipe[s] <= '0;
      mcarry <= '0;
    end else if (MulAccEn) begin
      mpipe[0] <= {{W{1'b0}}, IN_REG0} * {{W{1'b0}}, IN_REG1} + {{W{1'b0}}, IN_REG2};
      for (int s = 1; s < L; s++) mpipe[s] <= mpipe[s-1];
      if (!ArithRegOp) mcarry <= msum[2*W-1:W];
    end
  end

  typedef struct packed {
    logic [W-1:0] w;
    logic [4:0]   idx;
    logic         last;
  } exp_t;

  exp_t         sbq[$];
  logic [W-1:0] a_l [16];
  logic [W-1:0] c_l [16];
  logic [W-1:0] b_val;
  int           n_val;
  int           errs = 0;
  int           checks = 0;

  function automatic logic [W-1:0] rand72();
    logic [95:0] t;
    t = {$urandom, $urandom, $urandom};
    return t[W-1:0];
  endfunction

  // Reference A*b+C, schoolbook over limbs, queued as the expected result stream.
  task automatic push_model();
    logic [W-1:0]   cy;
    logic [2*W-1:0] t;
    cy = '0;
    for (int i = 0; i < n_val; i++) begin
      t  = {{W{1'b0}}, a_l[i]} * {{W{1'b0}}, b_val} + {{W{1'b0}}, c_l[i]} + {{W{1'b0}}, cy};
      sbq.push_back({t[W-1:0], 5'(i), 1'b0});
      cy = t[2*W-1:W];
    end
    sbq.push_back({cy, 5'(n_val), 1'b1});
  endtask

  // Runs one job to completion, popping and comparing each accepted result limb.
  task automatic run_job(input int in_pct, input int rdy_pct, input bit poke, output int lat);
    int           i, hs_k, first_k;
    bit           stalled, fin;
    logic [W-1:0] held_w;
    logic [4:0]   held_i;
    exp_t         e;
    i = 0; hs_k = -1; first_k = -1; stalled = 0; fin = 0;
    @(negedge clock);
    start = 1; b_word = b_val; num_limbs = 5'(n_val);
    @(negedge clock);
    start = 0;
    for (int k = 0; k < 3000 && !fin; k++) begin
      if (k > 0) @(negedge clock);
      start = poke && (k == 3);
      if (poke && k == 3) begin num_limbs = 5'd1; b_word = 72'h5A; end
      in_valid  = (i < n_val) && ($urandom_range(99) < in_pct);
      in_a      = a_l[i & 15];
      in_c      = c_l[i & 15];
      res_ready = ($urandom_range(99) < rdy_pct);
      #1;
      if (in_valid && in_ready) begin
        if (hs_k < 0) hs_k = k;
        i++;
      end
      if (res_valid && first_k < 0) first_k = k;
      if (stalled) begin
        checks++;
        if (!res_valid || res_word !== held_w || res_index !== held_i) begin
          errs++;
          $display("FAIL stall_hold: got v=%0b w=%0h i=%0d expected w=%0h i=%0d", res_valid, res_word, res_index, held_w, held_i);
        end
      end
      checks++;
      if (done !== (res_valid && res_ready && res_last)) begin
        errs++;
        $display("FAIL done_pulse: got %0b expected %0b", done, res_valid && res_ready && res_last);
      end
      stalled = res_valid && !res_ready;
      held_w  = res_word;
      held_i  = res_index;
      if (res_valid && res_ready) begin
        checks++;
        if (sbq.size() == 0) begin
          errs++;
          $display("FAIL extra_result: got w=%0h i=%0d expected none", res_word, res_index);
        end else begin
          e = sbq.pop_front();
          if (res_word !== e.w || res_index !== e.idx || res_last !== e.last) begin
            errs++;
            $display("FAIL result: got w=%0h i=%0d l=%0b expected w=%0h i=%0d l=%0b", res_word, res_index, res_last, e.w, e.idx, e.last);
          end
        end
        if (res_last) fin = 1;
      end
    end
    checks++;
    if (!fin) begin
      errs++;
      $display("FAIL job_timeout: got no carry limb expected completion");
    end
    lat = first_k - hs_k;
    @(negedge clock);
    start = 0; in_valid = 0; res_ready = 0;
    #1;
    checks++;
    if (busy !== 1'b0 || sbq.size() != 0) begin
      errs++;
      $display("FAIL job_end: got busy=%0b pending=%0d expected 0 0", busy, sbq.size());
    end
    sbq.delete();
  endtask

  task automatic test_reset();
    @(negedge clock); #1;
    checks++;
    if ({busy, done, in_ready, res_valid, res_last, MulAccEn, ArithOp, ArithRegOp} !== 8'b0000_0001 || res_index !== 5'd0) begin
      errs++;
      $display("FAIL reset_ctl: got %b idx=%0d expected 00000001 idx=0", {busy, done, in_ready, res_valid, res_last, MulAccEn, ArithOp, ArithRegOp}, res_index);
    end
    checks++;
    if (IN_REG0 !== '0 || IN_REG1 !== '0 || IN_REG2 !== '0) begin
      errs++;
      $display("FAIL reset_regs: got %0h %0h %0h expected 0 0 0", IN_REG0, IN_REG1, IN_REG2);
    end
  endtask

  task automatic test_single_limb();
    int lat;
    n_val = 1; a_l[0] = 72'd3; b_val = 72'd5; c_l[0] = 72'd7;
    sbq.push_back({72'd22, 5'd0, 1'b0});
    sbq.push_back({72'd0, 5'd1, 1'b1});
    run_job(100, 100, 0, lat);
    checks++;
    if (lat != 6) begin
      errs++;
      $display("FAIL latency: got %0d expected 6", lat);
    end
  endtask

  task automatic test_carry_paths();
    int lat;
    n_val = 2; b_val = {W{1'b1}};
    for (int i = 0; i < 2; i++) begin a_l[i] = {W{1'b1}}; c_l[i] = {W{1'b1}}; end
    sbq.push_back({72'd0, 5'd0, 1'b0});
    sbq.push_back({{W{1'b1}}, 5'd1, 1'b0});
    sbq.push_back({{W{1'b1}}, 5'd2, 1'b1});
    run_job(100, 100, 0, lat);
  endtask

  task automatic test_random_backpressure();
    int lat;
    for (int r = 0; r < 3; r++) begin
      n_val = 4; b_val = rand72();
      for (int i = 0; i < 4; i++) begin a_l[i] = rand72(); c_l[i] = rand72(); end
      push_model();
      run_job(50, 30, 0, lat);
    end
  endtask

  task automatic test_ignored_start();
    int lat;
    logic [4:0] bad [2];
    bad[0] = 5'd0; bad[1] = 5'd17;
    for (int j = 0; j < 2; j++) begin
      @(negedge clock);
      start = 1; num_limbs = bad[j]; b_word = rand72();
      @(negedge clock);
      start = 0; #1;
      checks++;
      if (busy !== 1'b0 || done !== 1'b0) begin
        errs++;
        $display("FAIL bad_start: got busy=%0b done=%0b n=%0d expected 0 0", busy, done, bad[j]);
      end
    end
    n_val = 3; b_val = rand72();
    for (int i = 0; i < 3; i++) begin a_l[i] = rand72(); c_l[i] = rand72(); end
    push_model();
    run_job(70, 60, 1, lat);
  endtask

  task automatic test_reset_midjob();
    int cnt, lat;
    bit seen;
    n_val = 4; b_val = rand72();
    for (int i = 0; i < 4; i++) begin a_l[i] = rand72(); c_l[i] = rand72(); end
    @(negedge clock);
    start = 1; b_word = b_val; num_limbs = 5'd4;
    @(negedge clock);
    start = 0; res_ready = 1; cnt = 0;
    for (int k = 0; k < 50 && cnt < 2; k++) begin
      if (k > 0) @(negedge clock);
      in_valid = 1; in_a = a_l[cnt]; in_c = c_l[cnt];
      #1;
      if (in_valid && in_ready) cnt++;
    end
    @(negedge clock);
    in_valid = 0; reset = 1;
    @(negedge clock);
    reset = 0; #1;
    checks++;
    if (cnt != 2 || busy !== 1'b0 || res_valid !== 1'b0 || done !== 1'b0) begin
      errs++;
      $display("FAIL reset_mid: got issued=%0d busy=%0b res_valid=%0b done=%0b expected 2 0 0 0", cnt, busy, res_valid, done);
    end
    seen = 0;
    for (int k = 0; k < 12; k++) begin
      @(negedge clock); #1;
      if (busy || res_valid || done) seen = 1;
    end
    checks++;
    if (seen) begin
      errs++;
      $display("FAIL reset_quiet: got activity after reset expected none");
    end
    b_val = rand72();
    for (int i = 0; i < 4; i++) begin a_l[i] = rand72(); c_l[i] = rand72(); end
    push_model();
    run_job(80, 80, 0, lat);
  endtask

  task automatic test_max_limbs();
    int lat;
    n_val = 16; b_val = {W{1'b1}};
    for (int i = 0; i < 16; i++) begin a_l[i] = {W{1'b1}}; c_l[i] = {W{1'b1}}; end
    sbq.push_back({72'd0, 5'd0, 1'b0});
    for (int i = 1; i <= 16; i++) sbq.push_back({{W{1'b1}}, 5'(i), (i == 16)});
    run_job(90, 70, 0, lat);
  endtask

  initial begin
    reset = 1; start = 0; b_word = '0; num_limbs = '0;
    in_valid = 0; in_a = '0; in_c = '0; res_ready = 0;
    repeat (3) @(posedge clock);
    @(negedge clock);
    reset = 0;
    test_reset();
    test_single_limb();
    test_carry_paths();
    test_random_backpressure();
    test_ignored_start();
    test_reset_midjob();
    test_max_limbs();
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
